// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port on-chip RAM between two
// Avalon-MM masters (0 = CPU data master, 1 = logging DMA). One access
// per cycle, 1-cycle read latency, out-of-range accesses are absorbed
// (writes dropped, reads return zero).
// Build option: define ONCHIP_ARB_ROUND_ROBIN_EN for round-robin ties;
// otherwise port 0 always wins a tie and no `last` pointer exists.

// Per-port request decode and response qualification.
module onchip_mem_arbiter_port (
  input  logic reset,
  input  logic read,
  input  logic write,
  input  logic gnt,
  input  logic rd_hit,
  output logic req,
  output logic wr,
  output logic waitrequest,
  output logic readdatavalid
);
  assign req           = read | write;
  // a simultaneous read+write is treated as a write
  assign wr            = write;
  assign waitrequest   = reset | ~gnt;
  assign readdatavalid = rd_hit;
endmodule

module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5120
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam int NUM_PORTS = 2;
  localparam int BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } mreq_t;

  mreq_t [NUM_PORTS-1:0] mreq;
  mreq_t                 sel;
  logic [NUM_PORTS-1:0]  rd_in, wr_in, req, wr_dec, gnt, rd_hit, wait_o, rdv_o;
  logic                  gnt_vld, gnt_id, in_range, rd_acc;
  logic                  rd_pend, rd_id, in_range_q;
  logic [DATA_W-1:0]     rdata;

  assign rd_in   = {m1_read, m0_read};
  assign wr_in   = {m1_write, m0_write};
  assign mreq[0] = {m0_address, m0_byteenable, m0_writedata, wr_dec[0]};
  assign mreq[1] = {m1_address, m1_byteenable, m1_writedata, wr_dec[1]};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign rd_hit[g] = rd_pend & (rd_id == 1'(g));
    onchip_mem_arbiter_port u_port (
      .reset         (reset),
      .read          (rd_in[g]),
      .write         (wr_in[g]),
      .gnt           (gnt[g]),
      .rd_hit        (rd_hit[g]),
      .req           (req[g]),
      .wr            (wr_dec[g]),
      .waitrequest   (wait_o[g]),
      .readdatavalid (rdv_o[g])
    );
  end

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
  logic last;

  // remember the most recent winner; reset to 1 so port 0 takes the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last <= 1'b1;
    else if (gnt_vld) last <= gnt_id;
  end

  // grant: a lone requester wins, a tie goes to the port that did not win last
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (req[0] && req[1]) gnt = last ? 2'b01 : 2'b10;
      else                  gnt = req;
    end
  end
`else
  // grant: fixed priority, port 0 wins every tie
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (req[0]) gnt = 2'b01;
      else        gnt = req;
    end
  end
`endif

  assign gnt_vld  = |gnt;
  assign gnt_id   = gnt[1];
  assign sel      = mreq[gnt_id];
  assign in_range = {1'b0, sel.addr} < DEPTH_W;
  assign rd_acc   = gnt_vld & ~sel.wr;

  assign mem_address    = sel.addr;
  assign mem_byteenable = sel.be;
  assign mem_writedata  = sel.wdata;
  assign mem_chipselect = gnt_vld & in_range;
  assign mem_write      = gnt_vld & sel.wr & in_range;
  assign mem_clken      = ~reset;

  // track the read in flight so its data is steered back next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      rd_id      <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      rd_pend <= rd_acc;
      if (rd_acc) begin
        rd_id      <= gnt_id;
        in_range_q <= in_range;
      end
    end
  end

  // out-of-range reads never touched the RAM, so return zero instead
  assign rdata = in_range_q ? mem_readdata : '0;

  assign m0_waitrequest   = wait_o[0];
  assign m1_waitrequest   = wait_o[1];
  assign m0_readdatavalid = rdv_o[0];
  assign m1_readdatavalid = rdv_o[1];
  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
endmodule
